// File: rtl/logreg_pkg.sv
// logreg_pkg: shared definitions for the logistic-regression engine.
//   - FSM state encoding (enum plus plain logic constants for the state register)
//   - piecewise-sigmoid breakpoints (11) and Q12 output levels (12)
//   - class threshold on the Q12 probability
//   - sm2s(): sign-magnitude to two's complement conversion
package logreg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC  = 3'd1,
    S_BIAS = 3'd2,
    S_ACT  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  localparam logic [2:0] ST_IDLE = 3'(S_IDLE);
  localparam logic [2:0] ST_ACC  = 3'(S_ACC);
  localparam logic [2:0] ST_BIAS = 3'(S_BIAS);
  localparam logic [2:0] ST_ACT  = 3'(S_ACT);
  localparam logic [2:0] ST_HOLD = 3'(S_HOLD);

  localparam int N_BP = 11;

  // Ascending; each is the inclusive lower bound of the next segment.
  localparam int SIG_BP [N_BP] = '{
    -12288, -8192, -6963, -5325, -3277, -1638,
    410, 2048, 3686, 5734, 7373
  };

  localparam logic [11:0] SIG_LVL [N_BP+1] = '{
    12'd41,   12'd205,  12'd614,  12'd819,  12'd1229, 12'd1638,
    12'd2048, 12'd2458, 12'd2867, 12'd3277, 12'd3482, 12'd3686
  };

  localparam logic [11:0] PROB_THRESH = 12'd2048;

  // Width-generic: the value occupies sm[dw-1:0], sign in bit dw-1.
  // Negative zero maps to 0.
  function automatic logic signed [63:0] sm2s(input logic [63:0] sm, input int dw);
    logic [63:0] mag;
    logic        neg;
    mag  = sm & ((64'd1 << (dw - 1)) - 64'd1);
    neg  = |((sm >> (dw - 1)) & 64'd1);
    sm2s = neg ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/logreg_engine_if.sv
// logreg_engine_if: parameter-write port, feature stream, result stream and
// status of the logistic-regression engine, bundled as one interface.
//   master : the side that loads parameters, sends features, takes results
//   slave  : the engine
// Signals: wr_en/wr_addr/wr_data (parameter write), in_valid/in_ready/in_data
// (feature beats), out_valid/out_ready/ypred (result), busy (status).
// prob (12-bit Q12 probability) exists only when LOGREG_PROB_EN is defined.
interface logreg_engine_if #(
  parameter int N_FEAT = 30,
  parameter int DW     = 16
);
  localparam int AW = $clog2(N_FEAT + 1);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          ypred;
  logic          busy;
`ifdef LOGREG_PROB_EN
  logic [11:0]   prob;
`endif

  modport master (
    output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, ypred, busy
`ifdef LOGREG_PROB_EN
    , input prob
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, ypred, busy
`ifdef LOGREG_PROB_EN
    , output prob
`endif
  );

endinterface

// File: rtl/logreg_sigmoid_pwl.sv
// logreg_sigmoid_pwl: combinational 12-segment piecewise sigmoid.
//   acc  in  ACCW  signed accumulator value
//   prob out 12    Q12 probability level of the segment containing acc
module logreg_sigmoid_pwl
  import logreg_pkg::*;
#(
  parameter int ACCW = 40
) (
  input  logic signed [ACCW-1:0] acc,
  output logic        [11:0]     prob
);

  logic [3:0] seg;

  // Breakpoints are ascending, so the last one passed gives the segment.
  always_comb begin
    seg = 4'd0;
    for (int i = 0; i < N_BP; i++) begin
      if (acc >= ACCW'(SIG_BP[i])) seg = 4'(i + 1);
    end
  end

  assign prob = SIG_LVL[seg];

endmodule

// File: rtl/logreg_engine.sv
// logreg_engine: logistic-regression inference engine.
// Holds N_FEAT sign-magnitude weights plus a bias, takes one feature per
// accepted beat, accumulates signed products, adds the bias, and registers
// the piecewise-sigmoid result and its class label.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears weights too)
//   bus    slave modport of logreg_engine_if (parameters N_FEAT/DW must match)
//
// Build option: define LOGREG_PROB_EN to expose the registered Q12
// probability on bus.prob; otherwise only ypred is produced.
//
// state | meaning
// IDLE  | waiting for first feature; parameter writes allowed
// ACC   | accepting features 1..N_FEAT-1, accumulating products
// BIAS  | adding bias to the accumulator
// ACT   | registering sigmoid output and class label
// HOLD  | result valid, waiting for out_ready
module logreg_engine
  import logreg_pkg::*;
#(
  parameter int            N_FEAT    = 30,
  parameter int            DW        = 16,
  parameter int            ACCW      = 40,
  parameter logic [DW-1:0] BIAS_INIT = 'h01B2
) (
  input  logic            clk,
  input  logic            rst_n,
  logreg_engine_if.slave  bus
);

  localparam int AW = $clog2(N_FEAT + 1);
  localparam int PW = 2 * (DW - 1);

  logic [2:0]             state;
  logic [AW-1:0]          idx;
  logic signed [ACCW-1:0] acc;
  logic [DW-1:0]          weight [N_FEAT];
  logic [DW-1:0]          bias;
  logic                   out_valid_q;
  logic                   ypred_q;
`ifdef LOGREG_PROB_EN
  logic [11:0]            prob_q;
`endif

  logic                   beat;
  logic [DW-1:0]          w_sel;
  logic [PW-1:0]          prod_mag;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] bias_s;
  logic [11:0]            sig_prob;

  assign bus.in_ready = (state == ST_IDLE) || (state == ST_ACC);
  assign beat         = bus.in_valid && bus.in_ready;

  // idx is 0 whenever the FSM is in IDLE, so this also picks weight 0
  // for the first beat.
  assign w_sel    = weight[idx];
  assign prod_mag = {{(DW-1){1'b0}}, w_sel[DW-2:0]} *
                    {{(DW-1){1'b0}}, bus.in_data[DW-2:0]};
  assign prod_ext = {{(ACCW-PW){1'b0}}, prod_mag};
  assign term     = (w_sel[DW-1] ^ bus.in_data[DW-1]) ? -prod_ext : prod_ext;
  assign bias_s   = ACCW'(sm2s(64'(bias), DW));

  logreg_sigmoid_pwl #(.ACCW(ACCW)) u_sigmoid (
    .acc  (acc),
    .prob (sig_prob)
  );

  // Parameter registers. Reads in the same cycle still see the old value,
  // so a beat coinciding with a write to weight 0 uses the previous weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) weight[i] <= '0;
      bias <= BIAS_INIT;
    end else if (state == ST_IDLE && bus.wr_en) begin
      if (bus.wr_addr < AW'(N_FEAT))
        weight[bus.wr_addr] <= bus.wr_data;
      else if (bus.wr_addr == AW'(N_FEAT))
        bias <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      ypred_q     <= 1'b0;
`ifdef LOGREG_PROB_EN
      prob_q      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (beat) begin
            // Entering ACC clears the accumulator: load the first product.
            acc <= term;
            if (N_FEAT == 1) begin
              idx   <= '0;
              state <= ST_BIAS;
            end else begin
              idx   <= AW'(1);
              state <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (beat) begin
            acc <= acc + term;
            if (idx == AW'(N_FEAT - 1)) begin
              idx   <= '0;
              state <= ST_BIAS;
            end else begin
              idx <= idx + AW'(1);
            end
          end
        end
        ST_BIAS: begin
          acc   <= acc + bias_s;
          state <= ST_ACT;
        end
        ST_ACT: begin
          ypred_q     <= (sig_prob > PROB_THRESH);
`ifdef LOGREG_PROB_EN
          prob_q      <= sig_prob;
`endif
          out_valid_q <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ypred     = ypred_q;
  assign bus.busy      = (state != ST_IDLE);
`ifdef LOGREG_PROB_EN
  assign bus.prob      = prob_q;
`endif

endmodule

// File: tb/tb_logreg_engine.sv
// Directed bench for logreg_engine: hand-computed vectors covering reset
// state, bias-only results, the strict threshold, sigmoid segment edges,
// negative zero, multi-feature sign handling, backpressure, input stalls,
// writes outside IDLE, out-of-range addresses and mid-vector reset.
module tb_logreg_engine;

  localparam int NF = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logreg_engine_if #(.N_FEAT(NF), .DW(16)) bus ();

  logreg_engine #(
    .N_FEAT(NF), .DW(16), .ACCW(40), .BIAS_INIT(16'h01B2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] feat [NF];

  logic [15:0] bnd_w [6] = '{16'h8001, 16'h8001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
  logic [15:0] bnd_f [6] = '{16'h3000, 16'h3001, 16'h1CCD, 16'h1CCC, 16'h019A, 16'h0199};
  logic [11:0] bnd_p [6] = '{12'd205,  12'd41,   12'd3686, 12'd3482, 12'd2458, 12'd2048};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic clr_feat();
    for (int i = 0; i < NF; i++) feat[i] = 16'h0000;
  endtask

  // Streams feat[], checks latency, result, optional hold, and release.
  // ypred expectation follows from the Q12 level: 1 iff level > 2048.
  task automatic run_vec(input string tag, input logic [11:0] exp_prob,
                         input bit stall, input bit acc_wr, input int hold);
    int n;
    logic exp_yp;
    exp_yp = (exp_prob > 12'd2048);
    for (int i = 0; i < NF; i++) begin
      if (stall && (i % 7) == 3) begin
        bus.in_valid = 1'b0;
        if (acc_wr && i == 10) begin
          bus.wr_en = 1'b1;
          bus.wr_addr = 5'd0;
          bus.wr_data = 16'h8005;
        end
        tick();
        bus.wr_en = 1'b0;
        chk({tag, "_stall_busy"}, 32'(bus.busy), 1);
      end
      bus.in_valid = 1'b1;
      bus.in_data = feat[i];
      tick();
    end
    bus.in_valid = 1'b0;
    chk({tag, "_bias_ovalid"}, 32'(bus.out_valid), 0);
    chk({tag, "_bias_iready"}, 32'(bus.in_ready), 0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 2);
    chk({tag, "_ypred"}, 32'(bus.ypred), 32'(exp_yp));
`ifdef LOGREG_PROB_EN
    chk({tag, "_prob"}, 32'(bus.prob), 32'(exp_prob));
`endif
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold_ovalid"}, 32'(bus.out_valid), 1);
      chk({tag, "_hold_iready"}, 32'(bus.in_ready), 0);
      chk({tag, "_hold_ypred"}, 32'(bus.ypred), 32'(exp_yp));
`ifdef LOGREG_PROB_EN
      chk({tag, "_hold_prob"}, 32'(bus.prob), 32'(exp_prob));
`endif
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_done_ovalid"}, 32'(bus.out_valid), 0);
    chk({tag, "_done_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done_iready"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ypred", 32'(bus.ypred), 0);
`ifdef LOGREG_PROB_EN
    chk("rst_prob", 32'(bus.prob), 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("rst_iready", 32'(bus.in_ready), 1);

    // Zero weights, reset bias 434 -> 2458.
    for (int i = 0; i < NF; i++) feat[i] = 16'(i * 37 + 1);
    run_vec("reset_bias", 12'd2458, 1'b0, 1'b0, 0);

    // Bias -2000 -> 1638.
    wr(5'd30, 16'h87D0);
    run_vec("neg_bias", 12'd1638, 1'b0, 1'b0, 0);

    // Bias 0, then an out-of-range write that must not land anywhere.
    wr(5'd30, 16'h0000);
    wr(5'd31, 16'h7FFF);
    clr_feat();
    wr(5'd0, 16'h0002);
    feat[0] = 16'h8100;
    run_vec("thresh_m512", 12'd2048, 1'b0, 1'b0, 0);

    // Segment edges via weight 0 / feature 0, bias 0.
    for (int k = 0; k < 6; k++) begin
      wr(5'd0, bnd_w[k]);
      feat[0] = bnd_f[k];
      run_vec($sformatf("bound%0d", k), bnd_p[k], 1'b0, 1'b0, 0);
    end

    // Negative-zero feature with max weight contributes 0; bias 410.
    wr(5'd0, 16'h7FFF);
    wr(5'd30, 16'h019A);
    feat[0] = 16'h8000;
    run_vec("neg_zero", 12'd2458, 1'b0, 1'b0, 0);

    // 3*100 + (-5)*(-200) + 7*10 + 2*500 = 2370 -> 2867, held 10 cycles.
    wr(5'd30, 16'h0000);
    wr(5'd0, 16'h0003);
    wr(5'd1, 16'h8005);
    wr(5'd2, 16'h0007);
    wr(5'd29, 16'h0002);
    clr_feat();
    feat[0] = 16'd100;
    feat[1] = 16'h80C8;
    feat[2] = 16'd10;
    feat[29] = 16'd500;
    run_vec("multi_bp", 12'd2867, 1'b0, 1'b0, 10);

    // Same vector with in_valid gaps and a write attempted during ACC.
    run_vec("stalled", 12'd2867, 1'b1, 1'b1, 0);

    // Weight 0 must still be 3: 3*137 = 411 -> 2458 (with -5 it would be 2048).
    clr_feat();
    feat[0] = 16'd137;
    run_vec("acc_wr_ignored", 12'd2458, 1'b0, 1'b0, 0);

    // Abort at idx 15, then a fresh vector must see zero weights and bias 434.
    for (int i = 0; i < NF; i++) feat[i] = 16'h83E8;
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = feat[i];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("midvec_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ovalid", 32'(bus.out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec("after_abort", 12'd2458, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
